compl_tx_arbiter: RTL and testbench

//  Shares the single completion request port of the PCIe TX engine between NUM_REQ

---
 rtl/compl_tx_arbiter_pkg.sv | 31 +++
 rtl/compl_tx_arbiter_rr_arbiter.sv | 30 +++
 rtl/compl_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_compl_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/compl_tx_arbiter_pkg.sv
// Shared definitions for the completion TX arbiter: packed completion header
// field offsets and FSM state encodings.
package compl_tx_arbiter_pkg;

    localparam int COMPL_HDR_W         = 62;

    localparam int COMPL_HDR_ADDR_LSB  = 0;
    localparam int COMPL_HDR_ADDR_W    = 13;
    localparam int COMPL_HDR_BE_LSB    = 13;
    localparam int COMPL_HDR_BE_W      = 8;
    localparam int COMPL_HDR_TAG_LSB   = 21;
    localparam int COMPL_HDR_TAG_W     = 8;
    localparam int COMPL_HDR_RID_LSB   = 29;
    localparam int COMPL_HDR_RID_W     = 16;
    localparam int COMPL_HDR_LEN_LSB   = 45;
    localparam int COMPL_HDR_LEN_W     = 10;
    localparam int COMPL_HDR_ATTR_LSB  = 55;
    localparam int COMPL_HDR_ATTR_W    = 2;
    localparam int COMPL_HDR_EP_LSB    = 57;
    localparam int COMPL_HDR_EP_W      = 1;
    localparam int COMPL_HDR_TD_LSB    = 58;
    localparam int COMPL_HDR_TD_W      = 1;
    localparam int COMPL_HDR_TC_LSB    = 59;
    localparam int COMPL_HDR_TC_W      = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/compl_tx_arbiter_rr_arbiter.sv
// Combinational rotate-priority encoder: first set request at or after ptr_i,
// wrapping, returned as one-hot plus index.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [2:0]   gnt_idx_o,
    output logic         gnt_vld_o
);

    int idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_idx_o  = 3'(idx);
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/compl_tx_arbiter.sv
// Shares the TX engine completion port among NUM_REQ sources with a watchdog.
// COMPL_ARB_FIXED_PRIO_EN: source 0 gets absolute priority, 1..NUM_REQ-1 round-robin.
module compl_tx_arbiter
    import compl_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int HDR_W       = COMPL_HDR_W,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_with_data_i,
    input  logic [NUM_REQ*HDR_W-1:0] req_hdr_i,
    output logic [NUM_REQ-1:0]       req_done_o,
    output logic                     req_compl_o,
    output logic                     req_compl_with_data_o,
    output logic [HDR_W-1:0]         req_hdr_o,
    input  logic                     compl_done_i,
    output logic [2:0]               grant_id_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYC - 1);
`ifdef COMPL_ARB_FIXED_PRIO_EN
    localparam logic [2:0] PTR_RST = 3'd1;
`else
    localparam logic [2:0] PTR_RST = 3'd0;
`endif

    logic [1:0]         state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         gid_q, gid_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic               wd_q, wd_d;
    logic               to_q, to_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;

    logic [NUM_REQ-1:0] arb_req, arb_gnt, win_oh;
    logic [2:0]         arb_idx, win_idx, ptr_nxt;
    logic               arb_vld, win_vld;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i     (arb_req),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    // Winner selection; in fixed-priority mode source 0 bypasses the rotation.
    always_comb begin
`ifdef COMPL_ARB_FIXED_PRIO_EN
        arb_req = {req_valid_i[NUM_REQ-1:1], 1'b0};
        win_vld = req_valid_i[0] | arb_vld;
        win_oh  = req_valid_i[0] ? NUM_REQ'(1) : arb_gnt;
        win_idx = req_valid_i[0] ? 3'd0 : arb_idx;
`else
        arb_req = req_valid_i;
        win_vld = arb_vld;
        win_oh  = arb_gnt;
        win_idx = arb_idx;
`endif
    end

    always_comb begin
        ptr_nxt = (gid_q == 3'(NUM_REQ - 1)) ? 3'd0 : gid_q + 3'd1;
`ifdef COMPL_ARB_FIXED_PRIO_EN
        if (ptr_nxt == 3'd0) ptr_nxt = 3'd1;
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        hdr_d   = hdr_q;
        wd_d    = wd_q;
        to_d    = to_q;
        wdog_d  = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_ISSUE;
                    gid_d   = win_idx;
                    hdr_d   = req_hdr_i[int'(win_idx)*HDR_W +: HDR_W];
                    wd_d    = |(win_oh & req_with_data_i);
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                wdog_d  = '0;
                to_d    = 1'b0;
            end
            ST_WAIT: begin
                // A completion on the expiry cycle wins over the abort.
                if (compl_done_i) begin
                    state_d = ST_RELEASE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = ST_RELEASE;
                    to_d    = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                ptr_d   = ptr_nxt;
                to_d    = 1'b0;
                wdog_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            gid_q   <= '0;
            hdr_q   <= '0;
            wd_q    <= 1'b0;
            to_q    <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            hdr_q   <= hdr_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
            wdog_q  <= wdog_d;
        end
    end

    assign req_compl_o           = (state_q == ST_ISSUE);
    assign req_compl_with_data_o = (state_q == ST_ISSUE) & wd_q;
    assign req_done_o            = (state_q == ST_RELEASE) ? (NUM_REQ'(1) << gid_q) : '0;
    assign timeout_o             = (state_q == ST_RELEASE) & to_q;
    assign busy_o                = (state_q != ST_IDLE);
    assign grant_id_o            = gid_q;
    assign req_hdr_o             = hdr_q;

endmodule

// File: tb/tb_compl_tx_arbiter.sv
// Randomized scoreboard bench for compl_tx_arbiter: a transaction-level model
// predicts issue/release slots, winners and headers; a monitor checks the DUT.
`timescale 1ns/1ps
module tb_compl_tx_arbiter;
    import compl_tx_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int HW = COMPL_HDR_W;
    localparam int T  = 16;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_with_data_i = '0;
    logic [N*HW-1:0] req_hdr_i = '0;
    logic [N-1:0]    req_done_o;
    logic            req_compl_o, req_compl_with_data_o;
    logic [HW-1:0]   req_hdr_o;
    logic            compl_done_i = 1'b0;
    logic [2:0]      grant_id_o;
    logic            busy_o, timeout_o;

    compl_tx_arbiter #(.NUM_REQ(N), .HDR_W(HW), .TIMEOUT_CYC(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_with_data_i(req_with_data_i), .req_hdr_i(req_hdr_i),
        .req_done_o(req_done_o), .req_compl_o(req_compl_o),
        .req_compl_with_data_o(req_compl_with_data_o), .req_hdr_o(req_hdr_o),
        .compl_done_i(compl_done_i), .grant_id_o(grant_id_o),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct { int slot; int g; logic [HW-1:0] hdr; logic wd; } iss_t;
    typedef struct { int slot; int g; logic to; } rel_t;
    iss_t exp_iss[$];
    rel_t exp_rel[$];

    int checks = 0, failures = 0;
    int slot = 0;
    always @(posedge clk) slot <= slot + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (slot %0d)", name, act, exp, slot);
        end
    endtask

    // Monitor: pops a prediction whenever the DUT presents an issue or a release.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_compl_o) begin
                iss_t e;
                if (exp_iss.size() == 0) chk("unexpected_issue", 1, 0);
                else begin
                    e = exp_iss.pop_front();
                    chk("issue_slot", slot, e.slot);
                    chk("issue_grant", grant_id_o, e.g);
                    chk("issue_hdr", req_hdr_o, e.hdr);
                    chk("issue_with_data", req_compl_with_data_o, e.wd);
                    chk("issue_busy", busy_o, 1);
                end
            end else if (req_compl_with_data_o) chk("with_data_no_req", 1, 0);
            if (req_done_o != '0) begin
                rel_t r;
                if (exp_rel.size() == 0) chk("unexpected_done", req_done_o, 0);
                else begin
                    r = exp_rel.pop_front();
                    chk("done_slot", slot, r.slot);
                    chk("done_vec", req_done_o, 64'd1 << r.g);
                    chk("done_timeout", timeout_o, r.to);
                end
            end else if (timeout_o) chk("timeout_no_done", 1, 0);
        end
    end

    // Stimulus policy and transaction-level model state.
    bit act[N], granted[N];
    int rel[N];
    int pct = 0, dmode = 0, spur_pct = 0;
    logic [N-1:0] mask = '0;
    bit scramble = 0, force_hdr = 0;
    logic [HW-1:0] forced_hdr = '0;
    int m_next = 0, m_issue = -10, m_rel = -10, m_done = -1, m_ptr = 0;

    function automatic logic [HW-1:0] rand_hdr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[HW-1:0];
    endfunction

    // Cycles after req_compl_o until compl_done_i; 0 means the TX engine never answers.
    function automatic int pick_delay();
        int r;
        case (dmode)
            1: return 5;
            2: return 0;
            3: return T;
            default: begin
                r = $urandom_range(9);
                if (r <= 6) return $urandom_range(8, 1);
                if (r == 7) return T;
                if (r == 8) return 0;
                return T - 1;
            end
        endcase
    endfunction

    function automatic int reset_ptr();
`ifdef COMPL_ARB_FIXED_PRIO_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        int g, d, idx;
        logic to;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            if (act[k] && granted[k] && slot >= rel[k]) begin
                act[k] = 0; granted[k] = 0; req_valid_i[k] = 1'b0;
            end
            if (!act[k]) begin
                if (mask[k] && $urandom_range(99) < pct) begin
                    act[k] = 1; granted[k] = 0;
                    req_valid_i[k] = 1'b1;
                    req_with_data_i[k] = force_hdr ? 1'b1 : 1'($urandom());
                    req_hdr_i[k*HW +: HW] = force_hdr ? forced_hdr : rand_hdr();
                end
            end else if (granted[k] && scramble) begin
                if ($urandom_range(3) == 0) begin
                    req_hdr_i[k*HW +: HW] = rand_hdr();
                    req_with_data_i[k] = 1'($urandom());
                end
                if ($urandom_range(7) == 0) req_valid_i[k] = 1'b0;
            end
        end
        compl_done_i = (slot == m_done);
        if (!compl_done_i && !(slot > m_issue && slot < m_rel) && $urandom_range(99) < spur_pct)
            compl_done_i = 1'b1;
        if (rst_n && slot + 1 >= m_next && req_valid_i != '0) begin
            g = -1;
`ifdef COMPL_ARB_FIXED_PRIO_EN
            if (req_valid_i[0]) g = 0;
            for (int i = 0; i < N; i++) begin
                idx = (m_ptr + i) % N;
                if (g < 0 && idx != 0 && req_valid_i[idx]) g = idx;
            end
`else
            for (int i = 0; i < N; i++) begin
                idx = (m_ptr + i) % N;
                if (g < 0 && req_valid_i[idx]) g = idx;
            end
`endif
            d = pick_delay();
            m_issue = slot + 1;
            if (d > 0 && d <= T) begin
                m_done = m_issue + d; m_rel = m_issue + d + 1; to = 1'b0;
            end else begin
                m_done = -1; m_rel = m_issue + T + 1; to = 1'b1;
            end
            m_next = m_rel + 2;
            m_ptr = (g + 1) % N;
            if (reset_ptr() == 1 && m_ptr == 0) m_ptr = 1;
            granted[g] = 1; rel[g] = m_rel;
            exp_iss.push_back('{m_issue, g, req_hdr_i[g*HW +: HW], req_with_data_i[g]});
            exp_rel.push_back('{m_rel, g, to});
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_done"}, req_done_o, 0);
        chk({tag, "_compl"}, req_compl_o, 0);
        chk({tag, "_wd"}, req_compl_with_data_o, 0);
        chk({tag, "_hdr"}, req_hdr_o, 0);
        chk({tag, "_gid"}, grant_id_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_to"}, timeout_o, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid_i = '0; req_with_data_i = '0; req_hdr_i = '0; compl_done_i = 1'b0;
        for (int k = 0; k < N; k++) begin act[k] = 0; granted[k] = 0; end
        exp_iss.delete(); exp_rel.delete();
        m_issue = -10; m_rel = -10; m_done = -1; m_ptr = reset_ptr();
        @(negedge clk);
        check_outputs_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_next = slot + 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check_outputs_zero("init");
        do_reset();

        // Lone request from source 1 with a recognisable header.
        forced_hdr = '0;
        forced_hdr[COMPL_HDR_TAG_LSB +: COMPL_HDR_TAG_W] = 8'h5A;
        forced_hdr[COMPL_HDR_LEN_LSB +: COMPL_HDR_LEN_W] = 10'd1;
        force_hdr = 1; mask = 3'b010; pct = 100; dmode = 1;
        step();
        mask = '0; force_hdr = 0;
        run(12);
        chk("t1_tag", req_hdr_o[COMPL_HDR_TAG_LSB +: COMPL_HDR_TAG_W], 8'h5A);
        chk("t1_gid", grant_id_o, 1);

        // All sources requesting continuously, fixed 5-cycle completion.
        mask = 3'b111; pct = 100; dmode = 1;
        run(60);
        // Watchdog expiry, then completion exactly on the expiry cycle.
        mask = 3'b001; dmode = 2;
        run(60);
        dmode = 3;
        run(60);
        // Spurious compl_done_i while idle.
        mask = '0; pct = 0; spur_pct = 50;
        run(30);

        // Randomized traffic with header/valid changes after grant.
        mask = 3'b111; pct = 30; dmode = 0; scramble = 1; spur_pct = 10;
        run(1500);
        scramble = 0; spur_pct = 0;

        // Reset while waiting on the TX engine.
        mask = 3'b001; pct = 100; dmode = 2;
        guard = 0;
        while (!(slot > m_issue + 2 && slot < m_rel - 2) && guard < 100) begin
            step(); guard++;
        end
        chk("t5_reached_wait", guard < 100, 1);
        do_reset();
        mask = 3'b100; dmode = 1;
        run(20);
        chk("t5_gid", grant_id_o, 2);

`ifdef COMPL_ARB_FIXED_PRIO_EN
        mask = 3'b101; pct = 100; dmode = 0;
        run(80);
        mask = 3'b100;
        run(60);
        chk("t6_gid", grant_id_o, 2);
`endif

        // Drain outstanding transactions.
        mask = '0; pct = 0;
        guard = 0;
        while (slot <= m_rel + 3 && guard < 4 * T) begin
            step(); guard++;
        end
        run(3);
        chk("drain_iss_empty", exp_iss.size(), 0);
        chk("drain_rel_empty", exp_rel.size(), 0);
        chk("drain_idle", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
